// File: rtl/dff_reg_arbiter.sv
// ---------------------------------------------------------------------------
// dff_reg_arbiter
//
// Purpose:
//   Shares one WIDTH-bit D-flip-flop register among NREQ requesters. Each
//   requester asks for one register operation (load data, set all, clear all
//   or toggle). Requesters are granted one at a time in round-robin order.
//   The winner's operation is applied to the register, the winner gets a
//   one-cycle ack, and a wrapping 8-bit counter tallies completed operations.
//   The register itself (Q and its complement Q_bar) lives inside this block.
//
//   Sequence per operation: IDLE -> WRITE -> ACK -> IDLE, so a new operation
//   can be accepted at most once every three cycles. Every output comes
//   straight from a flop.
//
// Parameters:
//   NREQ   number of requesters (2..8)
//   WIDTH  register width in bits
//
// Ports:
//   clk       single clock; all state changes on its rising edge
//   reset     synchronous, active-high; overrides everything else
//   req       per-requester request, held until that requester's ack
//   req_op    op of requester i at [2i+:2]: 00 load, 01 set, 10 clear, 11 toggle
//   req_data  load data of requester i at [i*WIDTH+:WIDTH] (used by op 00 only)
//   grant     one-hot current owner, all zero when idle
//   ack       one-cycle one-hot completion pulse to the owner
//   busy      high whenever the sequencer is not idle
//   Q         shared register value
//   Q_bar     complement of Q, kept as its own register
//   done_cnt  completed operations, wraps 255 -> 0
// ---------------------------------------------------------------------------
module dff_reg_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [2*NREQ-1:0]     req_op,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       ack,
    output logic                  busy,
    output logic [WIDTH-1:0]      Q,
    output logic [WIDTH-1:0]      Q_bar,
    output logic [7:0]            done_cnt
);

    localparam int IDX_W = $clog2(NREQ);

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_SET    = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    state_t             state_q,    state_d;
    logic [IDX_W-1:0]   cur_q,      cur_d;
    logic [IDX_W-1:0]   ptr_q,      ptr_d;
    logic [NREQ-1:0]    grant_q,    grant_d;
    logic [NREQ-1:0]    ack_q,      ack_d;
    logic               busy_q,     busy_d;
    logic [WIDTH-1:0]   q_q,        q_d;
    logic [WIDTH-1:0]   q_bar_q,    q_bar_d;
    logic [7:0]         done_cnt_q, done_cnt_d;

    // Round-robin pick helpers
    logic               found;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   cand;
    int                 scan_sum;

    // Owner's request, op and load data, selected by the latched owner index
    logic               cur_req;
    logic [1:0]         cur_op;
    logic [WIDTH-1:0]   cur_data;
    logic [IDX_W-1:0]   ptr_after_cur;

    // Round-robin search: scan ptr, ptr+1, ... wrapping at NREQ, and take the
    // first requester found. Only consulted while idle.
    always_comb begin
        found    = 1'b0;
        pick_idx = '0;
        cand     = '0;
        scan_sum = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan_sum = int'(ptr_q) + k;
            if (scan_sum >= NREQ) begin
                scan_sum = scan_sum - NREQ;
            end
            cand = IDX_W'(scan_sum);
            if (!found && req[cand]) begin
                found    = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // Slice out the owner's fields. Shifting keeps the selection width-safe
    // for any NREQ, not just powers of two.
    always_comb begin
        cur_req  = req[cur_q];
        cur_op   = 2'(req_op >> (2 * int'(cur_q)));
        cur_data = WIDTH'(req_data >> (WIDTH * int'(cur_q)));
        if (cur_q == IDX_W'(NREQ - 1)) begin
            ptr_after_cur = '0;
        end else begin
            ptr_after_cur = cur_q + 1'b1;
        end
    end

    // Sequencer next-state and registered-output logic. The owner's request
    // is re-checked at the WRITE edge so a requester can withdraw; that
    // withdrawal leaves the register, counter and pointer untouched, so the
    // same requester wins again if it comes straight back.
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        ack_d      = '0;
        q_d        = q_q;
        done_cnt_d = done_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                if (found) begin
                    cur_d   = pick_idx;
                    grant_d = NREQ'(1) << pick_idx;
                    state_d = ST_WRITE;
                end
            end

            ST_WRITE: begin
                if (cur_req) begin
                    unique case (cur_op)
                        OP_LOAD:   q_d = cur_data;
                        OP_SET:    q_d = '1;
                        OP_CLEAR:  q_d = '0;
                        OP_TOGGLE: q_d = ~q_q;
                        default:   q_d = q_q;
                    endcase
                    ack_d      = NREQ'(1) << cur_q;
                    done_cnt_d = done_cnt_q + 8'd1;
                    state_d    = ST_ACK;
                end else begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end

            ST_ACK: begin
                grant_d = '0;
                ptr_d   = ptr_after_cur;
                state_d = ST_IDLE;
            end

            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase

        q_bar_d = ~q_d;
        busy_d  = (state_d != ST_IDLE);
    end

    // State register. Reset wins over any operation in flight, so an op that
    // was in WRITE when reset arrives is simply dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cur_q      <= '0;
            ptr_q      <= '0;
            grant_q    <= '0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
            q_q        <= '0;
            q_bar_q    <= '1;
            done_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            q_q        <= q_d;
            q_bar_q    <= q_bar_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    assign grant    = grant_q;
    assign ack      = ack_q;
    assign busy     = busy_q;
    assign Q        = q_q;
    assign Q_bar    = q_bar_q;
    assign done_cnt = done_cnt_q;

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dff_reg_arbiter
//
// Self-checking bench for dff_reg_arbiter (NREQ=4, WIDTH=8). Inputs are
// driven and outputs sampled 1 time unit after each rising clock edge.
// Completed operations are predicted into a scoreboard queue when stimulus is
// driven and popped when the DUT raises ack.
// ---------------------------------------------------------------------------
module tb_dff_reg_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [7:0]  req_op;
    logic [31:0] req_data;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic        busy;
    logic [7:0]  Q;
    logic [7:0]  Q_bar;
    logic [7:0]  done_cnt;

    typedef struct packed {
        logic [3:0] ack;
        logic [7:0] q;
        logic [7:0] cnt;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    logic [7:0] exp_q;
    logic [7:0] exp_cnt;
    int         exp_ptr;

    logic [1:0] seq_op  [4] = '{2'b01, 2'b10, 2'b00, 2'b11};
    logic [7:0] seq_data[4] = '{8'h00, 8'h00, 8'h3C, 8'h00};
    logic [7:0] seq_q   [4] = '{8'hFF, 8'h00, 8'h3C, 8'hC3};

    dff_reg_arbiter #(.NREQ(4), .WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_op   (req_op),
        .req_data (req_data),
        .grant    (grant),
        .ack      (ack),
        .busy     (busy),
        .Q        (Q),
        .Q_bar    (Q_bar),
        .done_cnt (done_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Round-robin reference: first requester at or after p, wrapping.
    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (p + k) % 4;
            if (r[idx[1:0]]) return idx;
        end
        return 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [1:0] op, input logic [7:0] d);
        req_op   = (req_op & ~(8'b11 << (2 * i))) | (8'(op) << (2 * i));
        req_data = (req_data & ~(32'hFF << (8 * i))) | (32'(d) << (8 * i));
    endtask

    task automatic push_expect(input int w, input logic [7:0] newq);
        exp_q   = newq;
        exp_cnt = exp_cnt + 8'd1;
        sb.push_back({4'b0001 << w, exp_q, exp_cnt});
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req   = 4'b1111;
        step();
        step();
        reset   = 1'b0;
        req     = 4'b0000;
        exp_q   = 8'h00;
        exp_cnt = 8'd0;
        exp_ptr = 0;
        sb.delete();
    endtask

    // Reset held two cycles with every requester asking
    task automatic test_reset();
        reset = 1'b1;
        req   = 4'b1111;
        step();
        step();
        n_checks++; if (Q !== 8'h00) $display("[TB] FAIL reset_q: got %h want 00", Q); else n_pass++;
        n_checks++; if (Q_bar !== 8'hFF) $display("[TB] FAIL reset_qbar: got %h want ff", Q_bar); else n_pass++;
        n_checks++; if (grant !== 4'b0000) $display("[TB] FAIL reset_grant: got %b want 0000", grant); else n_pass++;
        n_checks++; if (ack !== 4'b0000) $display("[TB] FAIL reset_ack: got %b want 0000", ack); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done_cnt !== 8'd0) $display("[TB] FAIL reset_cnt: got %0d want 0", done_cnt); else n_pass++;
        reset   = 1'b0;
        req     = 4'b0000;
        exp_q   = 8'h00;
        exp_cnt = 8'd0;
        exp_ptr = 0;
        step();
        n_checks++; if (grant !== 4'b0000) $display("[TB] FAIL post_reset_grant: got %b want 0000", grant); else n_pass++;
    endtask

    // Single load from requester 2: grant at c+1, Q/ack at c+2, idle at c+3
    task automatic test_single_load();
        set_op(2, 2'b00, 8'hA5);
        req = 4'b0100;
        step();
        n_checks++; if (grant !== 4'b0100) $display("[TB] FAIL load_grant: got %b want 0100", grant); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("[TB] FAIL load_busy: got %b want 1", busy); else n_pass++;
        n_checks++; if (ack !== 4'b0000) $display("[TB] FAIL load_early_ack: got %b want 0000", ack); else n_pass++;
        push_expect(2, 8'hA5);
        step();
        n_checks++;
        if (sb.size() == 0) $display("[TB] FAIL load_sb: scoreboard empty");
        else begin
            e = sb.pop_front();
            if ({ack, Q, Q_bar, done_cnt} !== {e.ack, e.q, ~e.q, e.cnt})
                $display("[TB] FAIL load_done: got ack=%b Q=%h Qb=%h cnt=%0d want ack=%b Q=%h Qb=%h cnt=%0d",
                         ack, Q, Q_bar, done_cnt, e.ack, e.q, ~e.q, e.cnt);
            else n_pass++;
        end
        n_checks++; if (Q_bar !== 8'h5A) $display("[TB] FAIL load_qbar: got %h want 5a", Q_bar); else n_pass++;
        req = 4'b0000;
        step();
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL load_idle_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (ack !== 4'b0000) $display("[TB] FAIL load_ack_width: got %b want 0000", ack); else n_pass++;
        exp_ptr = 3;
    endtask

    // All four requesting continuously: grants rotate, 3 cycles apart
    task automatic test_round_robin();
        int last_cyc;
        int w;
        apply_reset();
        for (int i = 0; i < 4; i++) set_op(i, 2'b00, 8'(8'h10 + i));
        req      = 4'b1111;
        last_cyc = 0;
        for (int n = 0; n < 5; n++) begin
            step();
            w = pick(req, exp_ptr);
            n_checks++; if (grant !== (4'b0001 << w)) $display("[TB] FAIL rr_grant%0d: got %b want %b", n, grant, 4'b0001 << w); else n_pass++;
            if (n > 0) begin
                n_checks++; if (cyc - last_cyc !== 3) $display("[TB] FAIL rr_spacing%0d: got %0d want 3", n, cyc - last_cyc); else n_pass++;
            end
            last_cyc = cyc;
            push_expect(w, 8'(8'h10 + w));
            step();
            n_checks++;
            if (sb.size() == 0) $display("[TB] FAIL rr_sb%0d: scoreboard empty", n);
            else begin
                e = sb.pop_front();
                if ({ack, Q, Q_bar, done_cnt} !== {e.ack, e.q, ~e.q, e.cnt})
                    $display("[TB] FAIL rr_done%0d: got ack=%b Q=%h cnt=%0d want ack=%b Q=%h cnt=%0d",
                             n, ack, Q, done_cnt, e.ack, e.q, e.cnt);
                else n_pass++;
            end
            exp_ptr = (w + 1) % 4;
            if (n == 4) req = 4'b0000;
            step();
        end
    endtask

    // set, clear, load 3C, toggle on requester 0
    task automatic test_op_sequence();
        apply_reset();
        step();
        for (int k = 0; k < 4; k++) begin
            set_op(0, seq_op[k], seq_data[k]);
            req = 4'b0001;
            step();
            n_checks++; if (grant !== 4'b0001) $display("[TB] FAIL seq_grant%0d: got %b want 0001", k, grant); else n_pass++;
            push_expect(0, seq_q[k]);
            step();
            n_checks++;
            if (sb.size() == 0) $display("[TB] FAIL seq_sb%0d: scoreboard empty", k);
            else begin
                e = sb.pop_front();
                if ({ack, Q, Q_bar, done_cnt} !== {e.ack, e.q, ~e.q, e.cnt})
                    $display("[TB] FAIL seq_done%0d: got ack=%b Q=%h cnt=%0d want ack=%b Q=%h cnt=%0d",
                             k, ack, Q, done_cnt, e.ack, e.q, e.cnt);
                else n_pass++;
            end
            req = 4'b0000;
            step();
        end
        n_checks++; if (done_cnt !== 8'd4) $display("[TB] FAIL seq_cnt: got %0d want 4", done_cnt); else n_pass++;
        exp_ptr = 1;
    endtask

    // Owner withdraws during WRITE: nothing changes, pointer stays put
    task automatic test_abort();
        set_op(1, 2'b01, 8'h00);
        set_op(2, 2'b00, 8'h5A);
        req = 4'b0110;
        step();
        n_checks++; if (grant !== 4'b0010) $display("[TB] FAIL abort1_grant: got %b want 0010", grant); else n_pass++;
        req = 4'b0100;
        step();
        n_checks++; if (ack !== 4'b0000) $display("[TB] FAIL abort1_ack: got %b want 0000", ack); else n_pass++;
        n_checks++; if (grant !== 4'b0000) $display("[TB] FAIL abort1_grant_clr: got %b want 0000", grant); else n_pass++;
        n_checks++; if (Q !== 8'hC3) $display("[TB] FAIL abort1_q: got %h want c3", Q); else n_pass++;
        n_checks++; if (done_cnt !== 8'd4) $display("[TB] FAIL abort1_cnt: got %0d want 4", done_cnt); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL abort1_busy: got %b want 0", busy); else n_pass++;
        step();
        n_checks++; if (grant !== 4'b0100) $display("[TB] FAIL abort1_next: got %b want 0100", grant); else n_pass++;
        push_expect(2, 8'h5A);
        step();
        n_checks++;
        if (sb.size() == 0) $display("[TB] FAIL abort1_sb: scoreboard empty");
        else begin
            e = sb.pop_front();
            if ({ack, Q, Q_bar, done_cnt} !== {e.ack, e.q, ~e.q, e.cnt})
                $display("[TB] FAIL abort1_done: got ack=%b Q=%h cnt=%0d want ack=%b Q=%h cnt=%0d",
                         ack, Q, done_cnt, e.ack, e.q, e.cnt);
            else n_pass++;
        end
        req = 4'b0000;
        step();
        exp_ptr = 3;

        req = 4'b0110;
        step();
        n_checks++; if (grant !== 4'b0010) $display("[TB] FAIL abort2_grant: got %b want 0010", grant); else n_pass++;
        req = 4'b0100;
        step();
        n_checks++; if (ack !== 4'b0000) $display("[TB] FAIL abort2_ack: got %b want 0000", ack); else n_pass++;
        n_checks++; if (Q !== 8'h5A) $display("[TB] FAIL abort2_q: got %h want 5a", Q); else n_pass++;
        n_checks++; if (done_cnt !== 8'd5) $display("[TB] FAIL abort2_cnt: got %0d want 5", done_cnt); else n_pass++;
        req = 4'b0110;
        step();
        n_checks++; if (grant !== 4'b0010) $display("[TB] FAIL abort2_regrant: got %b want 0010", grant); else n_pass++;
        push_expect(1, 8'hFF);
        step();
        n_checks++;
        if (sb.size() == 0) $display("[TB] FAIL abort2_sb: scoreboard empty");
        else begin
            e = sb.pop_front();
            if ({ack, Q, Q_bar, done_cnt} !== {e.ack, e.q, ~e.q, e.cnt})
                $display("[TB] FAIL abort2_done: got ack=%b Q=%h cnt=%0d want ack=%b Q=%h cnt=%0d",
                         ack, Q, done_cnt, e.ack, e.q, e.cnt);
            else n_pass++;
        end
        req = 4'b0000;
        step();
        exp_ptr = 2;
    endtask

    // Reset arriving while a load of 77 over 11 sits in WRITE
    task automatic test_reset_mid_write();
        set_op(0, 2'b00, 8'h11);
        req = 4'b0001;
        step();
        push_expect(0, 8'h11);
        step();
        n_checks++;
        if (sb.size() == 0) $display("[TB] FAIL rmw_setup_sb: scoreboard empty");
        else begin
            e = sb.pop_front();
            if ({ack, Q, Q_bar, done_cnt} !== {e.ack, e.q, ~e.q, e.cnt})
                $display("[TB] FAIL rmw_setup: got ack=%b Q=%h cnt=%0d want ack=%b Q=%h cnt=%0d",
                         ack, Q, done_cnt, e.ack, e.q, e.cnt);
            else n_pass++;
        end
        req = 4'b0000;
        step();
        set_op(0, 2'b00, 8'h77);
        req = 4'b0001;
        step();
        n_checks++; if (grant !== 4'b0001) $display("[TB] FAIL rmw_grant: got %b want 0001", grant); else n_pass++;
        reset = 1'b1;
        step();
        n_checks++; if (Q !== 8'h00) $display("[TB] FAIL rmw_q: got %h want 00", Q); else n_pass++;
        n_checks++; if (Q_bar !== 8'hFF) $display("[TB] FAIL rmw_qbar: got %h want ff", Q_bar); else n_pass++;
        n_checks++; if (grant !== 4'b0000) $display("[TB] FAIL rmw_grant_clr: got %b want 0000", grant); else n_pass++;
        n_checks++; if (ack !== 4'b0000) $display("[TB] FAIL rmw_ack: got %b want 0000", ack); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL rmw_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done_cnt !== 8'd0) $display("[TB] FAIL rmw_cnt: got %0d want 0", done_cnt); else n_pass++;
        reset   = 1'b0;
        req     = 4'b0000;
        exp_q   = 8'h00;
        exp_cnt = 8'd0;
        exp_ptr = 0;
        step();
        n_checks++; if (ack !== 4'b0000) $display("[TB] FAIL rmw_late_ack: got %b want 0000", ack); else n_pass++;
    endtask

    // 256 back-to-back toggles from requester 0: counter wraps to 0
    task automatic test_cnt_wrap();
        set_op(0, 2'b11, 8'h00);
        req = 4'b0001;
        for (int n = 0; n < 256; n++) begin
            step();
            push_expect(0, ~exp_q);
            step();
            n_checks++;
            if (sb.size() == 0) $display("[TB] FAIL wrap_sb%0d: scoreboard empty", n);
            else begin
                e = sb.pop_front();
                if ({ack, Q, Q_bar, done_cnt} !== {e.ack, e.q, ~e.q, e.cnt})
                    $display("[TB] FAIL wrap_done%0d: got ack=%b Q=%h cnt=%0d want ack=%b Q=%h cnt=%0d",
                             n, ack, Q, done_cnt, e.ack, e.q, e.cnt);
                else n_pass++;
            end
            if (n == 255) req = 4'b0000;
            step();
        end
        n_checks++; if (done_cnt !== 8'd0) $display("[TB] FAIL wrap_cnt: got %0d want 0", done_cnt); else n_pass++;
        n_checks++; if (Q !== 8'h00) $display("[TB] FAIL wrap_q: got %h want 00", Q); else n_pass++;
        n_checks++; if (sb.size() !== 0) $display("[TB] FAIL wrap_sb_left: got %0d want 0", sb.size()); else n_pass++;
    endtask

    initial begin
        reset    = 1'b0;
        req      = 4'b0000;
        req_op   = 8'h00;
        req_data = 32'h0;
        exp_q    = 8'h00;
        exp_cnt  = 8'd0;
        exp_ptr  = 0;
        step();
        test_reset();
        test_single_load();
        test_round_robin();
        test_op_sequence();
        test_abort();
        test_reset_mid_write();
        test_cnt_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
